// File: rtl/pmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : pmem_responder
// Description : Single-port line memory that answers read/write requests
//               after a fixed latency and flags initiator protocol errors.
// Revision    : 1.0 - initial release
// ============================================================================
module pmem_responder #(
    parameter int LATENCY = 4,
    parameter int LINES   = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  logic [15:0]  pmem_address,
    input  logic [127:0] pmem_wdata,
    output logic [127:0] pmem_rdata,
    output logic         pmem_resp,
    output logic         busy,
    output logic         protocol_error
);

    localparam int IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           is_write_q, is_write_d;
    logic [15:0]    addr_q, addr_d;
    logic [127:0]   wdata_q, wdata_d;
    logic [127:0]   rdata_q, rdata_d;
    logic           resp_q, resp_d;
    logic           err_q, err_d;

    logic [127:0]   mem [LINES];

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_in_idx;
    logic             w_active;
    logic             w_unused_addr;

    assign w_idx         = addr_q[IDX_W+3:4];
    assign w_in_idx      = pmem_address[IDX_W+3:4];
    assign w_active      = is_write_q ? pmem_write : pmem_read;
    assign w_unused_addr = ^addr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        resp_d     = 1'b0;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (pmem_read ^ pmem_write) begin
                    is_write_d = pmem_write;
                    addr_d     = pmem_address;
                    wdata_d    = pmem_wdata;
                    cnt_d      = 4'(LATENCY - 1);
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        // Zero wait states: read data must be ready on the first edge.
                        state_d = RESP;
                        resp_d  = 1'b1;
                        if (!pmem_write) begin
                            rdata_d = mem[w_in_idx];
                        end
                    end
                end else if (pmem_read && pmem_write) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (!w_active) begin
                    // Initiator withdrew its request: abandon without response.
                    err_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    cnt_d   = 4'd0;
                    if (!is_write_q) begin
                        rdata_d = mem[w_idx];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            is_write_q <= 1'b0;
            addr_q     <= 16'h0;
            wdata_q    <= 128'h0;
            rdata_q    <= 128'h0;
            resp_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
            err_q      <= err_d;
        end
    end

    // Line storage has no reset; a reset forces IDLE so no commit can follow.
    always_ff @(posedge clk) begin
        if (state_q == RESP && is_write_q) begin
            mem[w_idx] <= wdata_q;
        end
    end

    assign pmem_rdata     = rdata_q;
    assign pmem_resp      = resp_q;
    assign busy           = (state_q != IDLE);
    assign protocol_error = err_q;

endmodule
`default_nettype wire

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to pmem_resp; legal range 1..15.
REQ-002 Parameter LINES, default 256: number of 128-bit lines held; power of two, 2..4096.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port pmem_read  input  1  line read request; initiator holds it high until pmem_resp.
REQ-006 Port pmem_write  input  1  line write request; initiator holds it high until pmem_resp.
REQ-007 Port pmem_address  input  16  byte address of the line.
REQ-008 Port pmem_wdata  input  128  write line data.
REQ-009 Port pmem_rdata  output  128  read line data, registered.
REQ-010 Port pmem_resp  output  1  completion strobe, exactly one cycle per accepted request.
REQ-011 Port busy  output  1  high while a request is accepted and not yet completed.
REQ-012 Port protocol_error  output  1  sticky flag for initiator protocol violations.

Function
REQ-013 The state machine SHALL have three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with exactly one of pmem_read or pmem_write high, the block SHALL capture the request type, pmem_address and pmem_wdata, load the counter with LATENCY-1, and enter WAIT (LATENCY>1) or RESP (LATENCY=1).
REQ-015 In IDLE with pmem_read and pmem_write both high, the block SHALL accept nothing, SHALL set protocol_error, and SHALL stay in IDLE.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the state SHALL move to RESP on the cycle after the counter reaches 1.
REQ-017 For a request first visible in IDLE in cycle T, pmem_resp SHALL be high only in cycle T+LATENCY.
REQ-018 pmem_resp SHALL be a registered output, high only in RESP, and RESP SHALL always return to IDLE after one cycle.
REQ-019 Line index SHALL be captured_address[log2(LINES)+3:4]; bits [3:0] are ignored, and bits above the index alias.
REQ-020 A read SHALL load pmem_rdata with the indexed line so that it is valid in the same cycle that pmem_resp is high; pmem_rdata SHALL then hold until the next read completes.
REQ-021 A write SHALL commit the captured pmem_wdata to the indexed line at the clock edge that ends the RESP cycle; a read of that line accepted afterwards returns the new data.
REQ-022 Changes to pmem_address or pmem_wdata after acceptance SHALL be ignored; the captured values are used.
REQ-023 If the active request signal drops in WAIT, the block SHALL set protocol_error, SHALL return to IDLE without pmem_resp, and SHALL NOT commit the write.
REQ-024 A request held high in the cycle after RESP SHALL be accepted as a new request, so back-to-back writeback-then-read sequences are served.
REQ-025 busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-026 protocol_error SHALL clear only on rst.

Reset
REQ-027 rst high SHALL force, asynchronously: state IDLE, counter 0, pmem_resp 0, busy 0, protocol_error 0, pmem_rdata 128'h0.
REQ-028 rst asserted mid-transaction SHALL abort it with no pmem_resp and no write commit.
REQ-029 Line storage SHALL NOT be reset; contents are undefined until written.
REQ-030 After rst deasserts, the first request SHALL be accepted in the first IDLE cycle.

Verification
REQ-031 Write then read, LATENCY=4: write addr 16'h0120 with data 128'hDEAD..BEEF -> pmem_resp in cycle T+4; then read 16'h012C -> pmem_rdata = 128'hDEAD..BEEF when resp is high.
REQ-032 Aliasing, LINES=256: write 16'h0F10 with A, write 16'h1F10 with B, read 16'h0F10 -> B.
REQ-033 LATENCY=1 back-to-back: write held across resp, followed directly by read -> two resps exactly 2 cycles apart; read data equals the new write data.
REQ-034 Withdraw: read dropped at cycle T+2 -> no resp, protocol_error=1, busy=0 at T+3; a following write completes normally.
REQ-035 Illegal request: pmem_read=pmem_write=1 for one cycle -> protocol_error=1, busy stays 0, no resp.
REQ-036 Reset mid-write: rst pulsed at cycle T+2 of a write to 16'h0040 -> all outputs reset immediately, no resp, and the line keeps its prior written value.
